judge3_vote_collector: RTL and testbench

Upstream front-end for the three-judge majority voter (`judge`).
- Synchronises and debounces three raw judge push-buttons.
- Collects votes during a timed voting round controlled by a state machine.
- Presents frozen, stable votes on `vote_a`/`vote_b`/`vote_c`, which drive the voter's `a`/`b`/`c` inputs, with `votes_valid` qualifying them.

---
 rtl/judge3_vote_collector.sv | 171 +++++++++++++++++
 tb/tb_judge3_vote_collector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/judge3_vote_collector.sv
// -----------------------------------------------------------------------------
// judge3_vote_collector
//
// Front-end for the three-judge majority voter. Each raw judge button is
// brought into the clk domain with a two-flop synchroniser and then debounced.
// A small state machine opens a timed voting round, collects sticky votes from
// the debounced levels, and presents them frozen to the voter.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   key_a/b/c    raw judge buttons, active-high, asynchronous to clk
//   start        open a voting round (acted on only in IDLE)
//   clear        acknowledge the result and return to IDLE (only in DONE)
//   vote_a/b/c   latched votes, wired to the voter's a/b/c inputs
//   votes_valid  high while in DONE; votes are frozen
//   busy         high while collecting votes
//   round_cnt    number of completed rounds, wraps at 256
// -----------------------------------------------------------------------------
module judge3_vote_collector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int VOTE_WINDOW     = 250000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       key_c,
  input  logic       start,
  input  logic       clear,
  output logic       vote_a,
  output logic       vote_b,
  output logic       vote_c,
  output logic       votes_valid,
  output logic       busy,
  output logic [7:0] round_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(VOTE_WINDOW);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] WIN_LAST = TW'(VOTE_WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  // Bit 2 = judge A, bit 1 = judge B, bit 0 = judge C throughout.
  logic [2:0]    key_raw;
  logic [2:0]    sync1_q, sync1_d;
  logic [2:0]    sync2_q, sync2_d;
  logic [2:0]    deb_q,   deb_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  state_t        state_q, state_d;
  logic [2:0]    vote_q,  vote_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    round_q, round_d;

  assign key_raw = {key_a, key_b, key_c};

  // ---------------------------------------------------------------------------
  // Synchroniser and debounce: a key level must disagree with the debounced
  // level for DEBOUNCE_CYCLES consecutive cycles before it is accepted. Any
  // agreeing cycle restarts the count, so short glitches are swallowed.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    sync1_d = key_raw;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round control: next state plus the vote, timer and round-count datapath.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    vote_d  = vote_q;
    timer_d = timer_q;
    round_d = round_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          vote_d  = '0;
          timer_d = '0;
        end
      end
      S_COLLECT: begin
        // Votes are sticky: releasing a key never withdraws a vote.
        vote_d  = vote_q | deb_q;
        timer_d = timer_q + TW'(1);
        // Early close on the edge the last vote latches, or timeout after
        // exactly VOTE_WINDOW collecting cycles; a vote latched on the timeout
        // edge is kept.
        if ((&vote_d) || (timer_q == WIN_LAST)) begin
          state_d = S_DONE;
          round_d = round_q + 8'd1;
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          vote_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        vote_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and also clears the synchroniser flops, so the
    // first debounced samples after reset are known zeros rather than stale
    // key levels.
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '{default: '0};
      state_q <= S_IDLE;
      vote_q  <= '0;
      timer_q <= '0;
      round_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before this edge, independent of statement order.
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      vote_q  <= vote_d;
      timer_q <= timer_d;
      round_q <= round_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registers, no path from key/start/clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    vote_a      = vote_q[2];
    vote_b      = vote_q[1];
    vote_c      = vote_q[0];
    votes_valid = (state_q == S_DONE);
    busy        = (state_q == S_COLLECT);
    round_cnt   = round_q;
  end

endmodule

// File: tb/tb_judge3_vote_collector.sv
// -----------------------------------------------------------------------------
// tb_judge3_vote_collector
//
// Self-checking bench for judge3_vote_collector with DEBOUNCE_CYCLES=4 and
// VOTE_WINDOW=20. A behavioural model tracks the expected outputs every cycle;
// directed scenarios add explicit checks on the corner cases, followed by a
// randomized stretch of key/start/clear/rst activity.
// -----------------------------------------------------------------------------
module tb_judge3_vote_collector;

  localparam int D = 4;
  localparam int W = 20;

  logic       clk;
  logic       rst;
  logic       key_a, key_b, key_c;
  logic       start, clear;
  logic       vote_a, vote_b, vote_c;
  logic       votes_valid, busy;
  logic [7:0] round_cnt;

  judge3_vote_collector #(
    .DEBOUNCE_CYCLES(D),
    .VOTE_WINDOW    (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_a      (key_a),
    .key_b      (key_b),
    .key_c      (key_c),
    .start      (start),
    .clear      (clear),
    .vote_a     (vote_a),
    .vote_b     (vote_b),
    .vote_c     (vote_c),
    .votes_valid(votes_valid),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. Keys reach the debouncer two edges after being sampled;
  // a debounced level follows the synchronised key once the two have disagreed
  // for D consecutive samples. Rounds follow the IDLE/COLLECT/DONE rules.
  // ---------------------------------------------------------------------------
  bit [2:0] m_s1, m_s2, m_deb, m_vote;
  int       m_diff [3];
  int       m_state;       // 0 idle, 1 collecting, 2 done
  int       m_cycles;      // edges spent collecting this round
  int       m_rounds;

  task automatic model_edge();
    bit [2:0] keys;
    bit [2:0] prev_deb;
    keys = {key_a, key_b, key_c};
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_vote = '0;
      for (int k = 0; k < 3; k++) m_diff[k] = 0;
      m_state = 0; m_cycles = 0; m_rounds = 0;
      return;
    end
    prev_deb = m_deb;
    for (int k = 0; k < 3; k++) begin
      if (m_s2[k] != m_deb[k]) begin
        m_diff[k]++;
        if (m_diff[k] == D) begin
          m_deb[k]  = m_s2[k];
          m_diff[k] = 0;
        end
      end else begin
        m_diff[k] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = keys;
    case (m_state)
      0: if (start) begin
        m_state  = 1;
        m_vote   = '0;
        m_cycles = 0;
      end
      1: begin
        m_vote   = m_vote | prev_deb;
        m_cycles = m_cycles + 1;
        if (m_vote == 3'b111 || m_cycles == W) begin
          m_state  = 2;
          m_rounds = (m_rounds + 1) % 256;
        end
      end
      default: if (clear) begin
        m_state = 0;
        m_vote  = '0;
      end
    endcase
  endtask

  // One clock edge: update the model with the inputs present at the edge, then
  // compare all outputs 1 time unit later.
  task automatic tick();
    logic [12:0] got;
    logic [12:0] exp;
    @(posedge clk);
    model_edge();
    #1;
    got = {vote_a, vote_b, vote_c, votes_valid, busy, round_cnt};
    exp = {m_vote, (m_state == 2), (m_state == 1), m_rounds[7:0]};
    check("cycle", {19'd0, got}, {19'd0, exp});
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!votes_valid && n < max) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, votes_valid}, 32'd1);
  endtask

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  int n;

  initial begin
    rst = 1'b1; key_a = 1'b0; key_b = 1'b0; key_c = 1'b0;
    start = 1'b0; clear = 1'b0;

    // Reset with keys toggling.
    key_a = 1'b1; tick();
    key_a = 1'b0; key_b = 1'b1; key_c = 1'b1; tick();
    check("rst_outputs", {19'd0, vote_a, vote_b, vote_c, votes_valid, busy, round_cnt}, 32'd0);
    rst = 1'b0; key_b = 1'b0; key_c = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);

    // Short pulse is rejected; a held key latches after edge n+6 and sticks.
    key_a = 1'b1; repeat (3) tick();
    key_a = 1'b0; repeat (4) tick();
    check("pulse_no_vote", {31'd0, vote_a}, 32'd0);
    key_a = 1'b1; repeat (6) tick();
    check("hold_before_latch", {31'd0, vote_a}, 32'd0);
    tick();
    check("hold_latch", {31'd0, vote_a}, 32'd1);
    key_a = 1'b0; repeat (5) tick();
    check("release_sticky", {31'd0, vote_a}, 32'd1);
    wait_valid(10, n);
    check("round1_votes", {29'd0, vote_a, vote_b, vote_c}, 32'b100);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_idle", {30'd0, votes_valid, busy}, 32'd0);

    // All three keys together: early close on the latching edge.
    start = 1'b1; tick(); start = 1'b0;
    key_a = 1'b1; key_b = 1'b1; key_c = 1'b1;
    wait_valid(W, n);
    check("early_close_edges", n, 32'd7);
    check("early_votes", {29'd0, vote_a, vote_b, vote_c}, 32'b111);
    check("early_busy", {31'd0, busy}, 32'd0);
    check("early_round_cnt", {24'd0, round_cnt}, 32'd2);
    check("early_voter_out", {31'd0, majority(vote_a, vote_b, vote_c)}, 32'd1);
    key_a = 1'b0; key_b = 1'b0; key_c = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (8) tick();

    // Only judge B: timeout exactly W cycles after entering COLLECT.
    key_b = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(2 * W, n);
    check("timeout_edges", n, W);
    check("timeout_votes", {29'd0, vote_a, vote_b, vote_c}, 32'b010);
    check("timeout_voter_out", {31'd0, majority(vote_a, vote_b, vote_c)}, 32'd0);

    // start together with clear in DONE: clear wins, no new round.
    key_b = 1'b0;
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    check("start_clear_done", {27'd0, vote_a, vote_b, vote_c, votes_valid, busy}, 32'd0);
    tick();
    check("start_clear_stays_idle", {31'd0, busy}, 32'd0);
    repeat (6) tick();

    // start during COLLECT does not restart the window.
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    start = 1'b1; repeat (3) tick(); start = 1'b0;
    wait_valid(2 * W, n);
    check("start_in_collect_edges", n, 32'd12);
    check("start_in_collect_votes", {29'd0, vote_a, vote_b, vote_c}, 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Reset mid-COLLECT with vote_a latched.
    start = 1'b1; tick(); start = 1'b0;
    key_a = 1'b1;
    n = 0;
    while (!vote_a && n < W) begin tick(); n++; end
    check("mid_collect_vote_a", {31'd0, vote_a}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_collect_reset", {19'd0, vote_a, vote_b, vote_c, votes_valid, busy, round_cnt}, 32'd0);

    // 256 fast rounds with all keys held: round_cnt wraps 255 -> 0.
    key_a = 1'b1; key_b = 1'b1; key_c = 1'b1;
    repeat (8) tick();
    for (int r = 1; r <= 256; r++) begin
      start = 1'b1; tick(); start = 1'b0;
      wait_valid(5, n);
      if (r == 255) check("round_cnt_255", {24'd0, round_cnt}, 32'd255);
      if (r == 256) check("round_cnt_wrap", {24'd0, round_cnt}, 32'd0);
      clear = 1'b1; tick(); clear = 1'b0;
    end
    key_a = 1'b0; key_b = 1'b0; key_c = 1'b0;

    // Randomized activity checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) key_a = ~key_a;
      if ($urandom_range(7) == 0) key_b = ~key_b;
      if ($urandom_range(7) == 0) key_c = ~key_c;
      start = ($urandom_range(3) == 0);
      clear = ($urandom_range(3) == 0);
      rst   = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; clear = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
